panel_word_writer: RTL

//  Front-panel entry engine for the TPU board bring-up path. Debounces NBTN raw buttons and

---
 rtl/panel_word_writer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/panel_word_writer.sv
// Front-panel word entry: debounced, auto-repeating buttons assemble switch chunks into
// words that are written out over a valid/ready port. Host DMA activity stalls new writes.
module panel_word_writer #(
    parameter int              NBTN         = 5,
    parameter int              SW_W         = 16,
    parameter int              WORD_W       = 64,
    parameter int              ADDR_W       = 10,
    parameter int              DEBOUNCE_CYC = 2_000_000,
    parameter int              RPT_DELAY    = 50_000_000,
    parameter int              RPT_PERIOD   = 10_000_000,
    parameter logic [NBTN-1:0] RPT_MASK     = 5'b00110
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NBTN-1:0]                 btn_raw,
    input  logic [SW_W-1:0]                 sw,
    input  logic                            host_active,
    output logic [NBTN-1:0]                 btn_pulse,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_W-1:0]               wr_addr,
    output logic [WORD_W-1:0]               wr_data,
    output logic [ADDR_W-1:0]               cur_addr,
    output logic [$clog2(WORD_W/SW_W):0]    chunk_idx,
    output logic                            drop_err
);

    localparam int NCHUNK  = WORD_W / SW_W;
    localparam int IDX_W   = $clog2(NCHUNK) + 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NCHUNK - 1);

    localparam int B_COMMIT = 0;
    localparam int B_NEXT   = 1;
    localparam int B_PREV   = 2;
    localparam int B_CLEAR  = 3;
    localparam int B_FLUSH  = 4;

    if (WORD_W % SW_W != 0) begin : g_bad_width
        $error("panel_word_writer: WORD_W must be a multiple of SW_W");
    end

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_REQ     = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    // Button input path state
    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  stable_q, stable_d;
    logic [NBTN-1:0]  stable_prev_q, stable_prev_d;
    logic [NBTN-1:0]  btn_pulse_q, btn_pulse_d;
    logic [NBTN-1:0]  rpt_first_q, rpt_first_d;
    logic [DB_W-1:0]  db_cnt_q  [NBTN];
    logic [DB_W-1:0]  db_cnt_d  [NBTN];
    logic [RPT_W-1:0] rpt_cnt_q [NBTN];
    logic [RPT_W-1:0] rpt_cnt_d [NBTN];

    // Word assembly / write port state
    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              drop_err_q, drop_err_d;

    logic act_clear, act_flush, act_commit, act_next, act_prev, act_any;

    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        rpt_first_d   = rpt_first_q;
        btn_pulse_d   = '0;
        for (int i = 0; i < NBTN; i++) begin
            db_cnt_d[i]  = '0;
            rpt_cnt_d[i] = rpt_cnt_q[i];

            // Any cycle where the synced level agrees with stable restarts the count
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            if (!stable_q[i] || !stable_prev_q[i]) begin
                rpt_cnt_d[i]   = '0;
                rpt_first_d[i] = 1'b1;
                btn_pulse_d[i] = stable_q[i];
            end else if (RPT_MASK[i]) begin
                if (rpt_first_q[i] ? (rpt_cnt_q[i] == DELAY_LAST)
                                   : (rpt_cnt_q[i] == PERIOD_LAST)) begin
                    rpt_cnt_d[i]   = '0;
                    rpt_first_d[i] = 1'b0;
                    btn_pulse_d[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // One action per cycle; lower-priority pulses in the same cycle simply vanish
    always_comb begin
        act_clear  = btn_pulse_q[B_CLEAR];
        act_flush  = !act_clear && btn_pulse_q[B_FLUSH];
        act_commit = !act_clear && !btn_pulse_q[B_FLUSH] && btn_pulse_q[B_COMMIT];
        act_next   = !act_clear && !btn_pulse_q[B_FLUSH] && !btn_pulse_q[B_COMMIT]
                     && btn_pulse_q[B_NEXT];
        act_prev   = !act_clear && !btn_pulse_q[B_FLUSH] && !btn_pulse_q[B_COMMIT]
                     && !btn_pulse_q[B_NEXT] && btn_pulse_q[B_PREV];
        act_any    = |btn_pulse_q;
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        cur_addr_d = cur_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        drop_err_d = drop_err_q;

        unique case (state_q)
            ST_COLLECT: begin
                if (act_clear) begin
                    word_d = '0;
                    idx_d  = '0;
                end else if (act_flush) begin
                    if (idx_q != '0) state_d = ST_REQ;
                end else if (act_commit) begin
                    for (int c = 0; c < NCHUNK; c++) begin
                        if (idx_q == IDX_W'(c)) word_d[c*SW_W +: SW_W] = sw;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = ST_REQ;
                end else if (act_next) begin
                    cur_addr_d = cur_addr_q + 1'b1;
                end else if (act_prev) begin
                    cur_addr_d = cur_addr_q - 1'b1;
                end
            end

            ST_REQ: begin
                if (act_any) drop_err_d = 1'b1;
                if (!host_active) begin
                    state_d    = ST_WRITE;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = cur_addr_q;
                    wr_data_d  = word_q;
                end
            end

            ST_WRITE: begin
                // Once offered, the write is held until taken regardless of host_active
                if (act_any) drop_err_d = 1'b1;
                if (wr_ready) begin
                    state_d    = ST_COLLECT;
                    wr_valid_d = 1'b0;
                    cur_addr_d = cur_addr_q + 1'b1;
                    word_d     = '0;
                    idx_d      = '0;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            btn_pulse_q   <= '0;
            rpt_first_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_q[i]  <= '0;
                rpt_cnt_q[i] <= '0;
            end
            state_q    <= ST_COLLECT;
            word_q     <= '0;
            idx_q      <= '0;
            cur_addr_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            btn_pulse_q   <= btn_pulse_d;
            rpt_first_q   <= rpt_first_d;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            state_q    <= state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            cur_addr_q <= cur_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign btn_pulse = btn_pulse_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cur_addr  = cur_addr_q;
    assign chunk_idx = idx_q;
    assign drop_err  = drop_err_q;

endmodule
